// File: rtl/hood_mode_request_arbiter.sv
// Debounces NUM_REQ toggle channels, checks each press against a per-mode permission mask,
// and issues one held mode-transition request followed by a cooldown lockout.
module hood_mode_request_arbiter #(
  parameter int MODE_WIDTH = 3,
  parameter int NUM_MODES = 6,
  parameter int NUM_REQ = 4,
  parameter logic [NUM_REQ*MODE_WIDTH-1:0] TARGET_MODES = {3'd0, 3'd3, 3'd2, 3'd1},
  parameter logic [NUM_REQ*NUM_MODES-1:0] ALLOWED = '1,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int COOLDOWN_CYCLES = 16,
  localparam int CH_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [MODE_WIDTH-1:0] current_mode,
  input  logic [NUM_REQ-1:0]    toggle_in,
  input  logic                  req_ready,
  output logic                  req_valid,
  output logic [MODE_WIDTH-1:0] req_target,
  output logic [CH_W-1:0]       req_channel,
  output logic                  reject,
  output logic                  drop,
  output logic                  busy,
  output logic [1:0]            dbg_state
);

  // Handshake: req_valid rises with req_target/req_channel stable and holds them unchanged
  // until an edge samples req_valid && req_ready; that edge completes the transfer.

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int CD_W  = (COOLDOWN_CYCLES > 0) ? $clog2(COOLDOWN_CYCLES + 1) : 1;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REQ      = 2'd1,
    ST_COOLDOWN = 2'd2
  } state_t;

  state_t               state;
  logic [CD_W-1:0]      cd_cnt;
  logic [CNT_W-1:0]     cnt [NUM_REQ];
  logic [NUM_REQ-1:0]   ev;

  logic                  found;
  logic                  lost;
  logic                  permit;
  logic [CH_W-1:0]       win_ch;
  logic [MODE_WIDTH-1:0] win_target;

  assign dbg_state = state;

  // Saturating counters give exactly one event per press, even if the input stays high.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int r = 0; r < NUM_REQ; r++) cnt[r] <= '0;
      ev <= '0;
    end else begin
      for (int r = 0; r < NUM_REQ; r++) begin
        if (!toggle_in[r]) begin
          cnt[r] <= '0;
          ev[r]  <= 1'b0;
        end else begin
          ev[r] <= (cnt[r] == CNT_W'(DEBOUNCE_CYCLES - 1));
          if (cnt[r] != CNT_W'(DEBOUNCE_CYCLES)) cnt[r] <= cnt[r] + CNT_W'(1);
        end
      end
    end
  end

  // Fixed priority: lowest-index event wins; out-of-range modes never match, so they reject.
  always_comb begin
    found      = 1'b0;
    lost       = 1'b0;
    permit     = 1'b0;
    win_ch     = '0;
    win_target = '0;
    for (int r = 0; r < NUM_REQ; r++) begin
      if (ev[r]) begin
        if (found) begin
          lost = 1'b1;
        end else begin
          found      = 1'b1;
          win_ch     = CH_W'(r);
          win_target = TARGET_MODES[r*MODE_WIDTH +: MODE_WIDTH];
          for (int m = 0; m < NUM_MODES; m++)
            if (current_mode == MODE_WIDTH'(m)) permit = ALLOWED[r*NUM_MODES+m];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= ST_IDLE;
      cd_cnt      <= '0;
      req_valid   <= 1'b0;
      req_target  <= '0;
      req_channel <= '0;
      reject      <= 1'b0;
      drop        <= 1'b0;
      busy        <= 1'b0;
    end else begin
      reject <= 1'b0;
      drop   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (found) begin
            drop <= lost;
            if (permit) begin
              state       <= ST_REQ;
              req_valid   <= 1'b1;
              req_target  <= win_target;
              req_channel <= win_ch;
              busy        <= 1'b1;
            end else begin
              reject <= 1'b1;
            end
          end
        end
        ST_REQ: begin
          drop <= |ev;
          if (req_ready) begin
            req_valid <= 1'b0;
            if (COOLDOWN_CYCLES == 0) begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end else begin
              state  <= ST_COOLDOWN;
              cd_cnt <= CD_W'(COOLDOWN_CYCLES);
            end
          end
        end
        ST_COOLDOWN: begin
          drop   <= |ev;
          cd_cnt <= cd_cnt - CD_W'(1);
          if (cd_cnt <= CD_W'(1)) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hood_mode_request_arbiter.sv
// Directed bench for hood_mode_request_arbiter: a default instance plus one with
// channel 0 forbidden in mode 2, both driven from the same stimulus.
module tb_hood_mode_request_arbiter;

  logic       clk;
  logic       rstn;
  logic [2:0] current_mode;
  logic [3:0] toggle_in;
  logic       req_ready;

  logic       req_valid, reject, drop, busy;
  logic [2:0] req_target;
  logic [1:0] req_channel, dbg_state;

  logic       b_req_valid, b_reject, b_drop, b_busy;
  logic [2:0] b_req_target;
  logic [1:0] b_req_channel, b_dbg_state;

  int checks = 0;
  int errors = 0;

  hood_mode_request_arbiter dut (
    .clk(clk), .rstn(rstn), .current_mode(current_mode), .toggle_in(toggle_in),
    .req_ready(req_ready), .req_valid(req_valid), .req_target(req_target),
    .req_channel(req_channel), .reject(reject), .drop(drop), .busy(busy),
    .dbg_state(dbg_state)
  );

  hood_mode_request_arbiter #(.ALLOWED(24'hFF_FFFB)) dut_b (
    .clk(clk), .rstn(rstn), .current_mode(current_mode), .toggle_in(toggle_in),
    .req_ready(req_ready), .req_valid(b_req_valid), .req_target(b_req_target),
    .req_channel(b_req_channel), .reject(b_reject), .drop(b_drop), .busy(b_busy),
    .dbg_state(b_dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 60 && (busy || b_busy); i++) tick();
    chk(tag, 32'(busy | b_busy), 32'd0);
  endtask

  int  busy_cnt;
  int  drops;
  int  hs;
  logic any_v, any_r, stable_ok;

  initial begin
    rstn = 1'b0; toggle_in = '0; req_ready = 1'b0; current_mode = '0;
    repeat (2) tick();
    chk("rst_valid", 32'(req_valid), 32'd0);
    chk("rst_target", 32'(req_target), 32'd0);
    chk("rst_channel", 32'(req_channel), 32'd0);
    chk("rst_flags", 32'({reject, drop, busy}), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'd0);
    rstn = 1'b1;
    repeat (2) tick();

    // Basic press on ch1, ready always high
    req_ready = 1'b1; toggle_in = 4'b0010;
    repeat (3) tick();
    chk("t1_early3", 32'(req_valid), 32'd0);
    tick();
    chk("t1_early4", 32'(req_valid), 32'd0);
    toggle_in = '0;
    tick();
    chk("t1_valid", 32'(req_valid), 32'd1);
    chk("t1_target", 32'(req_target), 32'd2);
    chk("t1_channel", 32'(req_channel), 32'd1);
    chk("t1_busy", 32'(busy), 32'd1);
    busy_cnt = 1;
    tick();
    chk("t1_valid_1cyc", 32'(req_valid), 32'd0);
    if (busy) busy_cnt++;
    for (int i = 0; i < 40 && busy; i++) begin
      tick();
      if (busy) busy_cnt++;
    end
    chk("t1_busy_len", 32'(busy_cnt), 32'd17);
    wait_idle("t1_idle");

    // Short press on ch2 must not qualify
    toggle_in = 4'b0100;
    repeat (3) tick();
    toggle_in = '0;
    any_v = 1'b0; any_r = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      any_v |= req_valid;
      any_r |= reject;
    end
    chk("t2_no_valid", 32'(any_v), 32'd0);
    chk("t2_no_reject", 32'(any_r), 32'd0);

    // ch0 in mode 2: forbidden in dut_b, allowed in dut
    current_mode = 3'd2; toggle_in = 4'b0001;
    repeat (4) tick();
    toggle_in = '0;
    tick();
    chk("t3_b_reject", 32'(b_reject), 32'd1);
    chk("t3_b_valid", 32'(b_req_valid), 32'd0);
    chk("t3_b_busy", 32'(b_busy), 32'd0);
    chk("t3_a_valid", 32'(req_valid), 32'd1);
    chk("t3_a_target", 32'(req_target), 32'd1);
    tick();
    chk("t3_b_reject_pulse", 32'(b_reject), 32'd0);
    chk("t3_b_busy2", 32'(b_busy), 32'd0);
    wait_idle("t3_idle");
    current_mode = 3'd0;

    // Simultaneous ch0 and ch3: ch0 wins, ch3 dropped
    toggle_in = 4'b1001;
    repeat (4) tick();
    toggle_in = '0;
    tick();
    chk("t4_valid", 32'(req_valid), 32'd1);
    chk("t4_channel", 32'(req_channel), 32'd0);
    chk("t4_target", 32'(req_target), 32'd1);
    chk("t4_drop", 32'(drop), 32'd1);
    tick();
    chk("t4_drop_pulse", 32'(drop), 32'd0);
    wait_idle("t4_idle");

    // Backpressure: hold request 10 cycles, ch2 press in the window is dropped
    req_ready = 1'b0; toggle_in = 4'b0010;
    repeat (4) tick();
    toggle_in = '0;
    tick();
    chk("t5_valid", 32'(req_valid), 32'd1);
    stable_ok = 1'b1; drops = 0;
    for (int i = 0; i < 10; i++) begin
      if (i == 0) toggle_in = 4'b0100;
      if (i == 4) toggle_in = '0;
      tick();
      if (!(req_valid === 1'b1 && req_target === 3'd2 && req_channel === 2'd1)) stable_ok = 1'b0;
      drops += int'(drop);
    end
    chk("t5_stable", 32'(stable_ok), 32'd1);
    chk("t5_drops", 32'(drops), 32'd1);
    req_ready = 1'b1;
    hs = 0;
    for (int i = 0; i < 20; i++) begin
      if (req_valid && req_ready) hs++;
      tick();
    end
    chk("t5_handshakes", 32'(hs), 32'd1);
    wait_idle("t5_idle");

    // Reset during cooldown with ch0 held high
    toggle_in = 4'b0001;
    repeat (4) tick();
    tick();
    chk("t6_valid", 32'(req_valid), 32'd1);
    repeat (4) tick();
    chk("t6_cooldown", 32'(busy), 32'd1);
    rstn = 1'b0;
    #1;
    chk("t6_rst_outs", 32'({req_valid, req_target, req_channel, reject, drop, busy}), 32'd0);
    chk("t6_rst_state", 32'(dbg_state), 32'd0);
    tick();
    rstn = 1'b1;
    repeat (3) tick();
    chk("t6_fresh3", 32'(req_valid), 32'd0);
    tick();
    chk("t6_fresh4", 32'(req_valid), 32'd0);
    tick();
    chk("t6_revalid", 32'(req_valid), 32'd1);
    chk("t6_channel", 32'(req_channel), 32'd0);
    chk("t6_target", 32'(req_target), 32'd1);
    toggle_in = '0;
    wait_idle("t6_idle");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
